// File: rtl/hazard_scoreboard.sv
// Purpose : D-stage hazard scoreboard; tracks in-flight GRF writers through NSTAGE stages and times the MD unit.
// Latency : stall/fwd_sel are combinational from registered entries and current D inputs; a writer issued at edge t is seen at stage k in cycle t+k-1.
// Backpressure: stall freezes PC and F/D and injects a bubble into E; flush clears all tracked writers.
// Ports   : clk, reset_n (sync, active-low); d_valid/d_we/d_a3/d_tnew describe the D writer;
//           d_src/d_tuse give NREAD source channels; d_md_start/d_md_div/d_md_use drive MD timing;
//           flush clears entries; outputs stall, fwd_sel (NREAD x SELW, 0 = GRF, k = stage k bus), md_busy.
// Config  : define HS_MDU_EN to build the MD busy counter and MD stall; otherwise md_busy is tied 0.
module hazard_scoreboard #(
   parameter  int NREAD       = 2,
   parameter  int NSTAGE      = 3,
   parameter  int TW          = 2,
   parameter  int MD_MULT_CYC = 5,
   parameter  int MD_DIV_CYC  = 10,
   localparam int SELW        = $clog2(NSTAGE + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   d_valid,
   input  logic                   d_we,
   input  logic [4:0]             d_a3,
   input  logic [TW-1:0]          d_tnew,
   input  logic [NREAD*5-1:0]     d_src,
   input  logic [NREAD*TW-1:0]    d_tuse,
   input  logic                   d_md_start,
   input  logic                   d_md_div,
   input  logic                   d_md_use,
   input  logic                   flush,
   output logic                   stall,
   output logic [NREAD*SELW-1:0]  fwd_sel,
   output logic                   md_busy
);

   typedef struct packed {
      logic          vld;
      logic [4:0]    a3;
      logic [TW-1:0] tnew;
   } ent_t;

   // ent_q[0] is stage 1 (E), ent_q[NSTAGE-1] is stage NSTAGE (W)
   ent_t ent_q [NSTAGE];

   logic          issue;
   logic          data_stall;
   logic          md_stall;
   logic [4:0]    src;
   logic [TW-1:0] tuse;
   logic          found;
   logic [TW-1:0] hit_tnew;
   logic [SELW-1:0] hit_k;

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? t : t - TW'(1);
   endfunction

   assign stall = d_valid & (data_stall | md_stall);
   assign issue = d_valid & ~stall;

   // Only the youngest matching writer is considered: an older stage may
   // hold a stale value of the same register.
   always_comb begin
      data_stall = 1'b0;
      fwd_sel    = '0;
      src        = '0;
      tuse       = '0;
      found      = 1'b0;
      hit_tnew   = '0;
      hit_k      = '0;
      for (int c = 0; c < NREAD; c++) begin
         src      = d_src[5*c +: 5];
         tuse     = d_tuse[TW*c +: TW];
         found    = 1'b0;
         hit_tnew = '0;
         hit_k    = '0;
         for (int k = 0; k < NSTAGE; k++) begin
            if (!found && ent_q[k].vld && (ent_q[k].a3 == src) && (src != 5'd0)) begin
               found    = 1'b1;
               hit_tnew = ent_q[k].tnew;
               hit_k    = SELW'(k + 1);
            end
         end
         if (found && (hit_tnew > tuse))
            data_stall = 1'b1;
         // tnew != 0 but not stalling: the result is picked up by a later
         // stage forwarder, so read the GRF path here.
         if (found && (hit_tnew == '0))
            fwd_sel[SELW*c +: SELW] = hit_k;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         for (int k = 0; k < NSTAGE; k++)
            ent_q[k] <= '0;
      end else begin
         // A stalled D instruction leaves a bubble (vld=0) in stage 1.
         ent_q[0].vld  <= issue & d_we & (d_a3 != 5'd0);
         ent_q[0].a3   <= d_a3;
         ent_q[0].tnew <= d_tnew;
         for (int k = 1; k < NSTAGE; k++) begin
            ent_q[k].vld  <= ent_q[k-1].vld;
            ent_q[k].a3   <= ent_q[k-1].a3;
            ent_q[k].tnew <= sat_dec(ent_q[k-1].tnew);
         end
      end
   end

`ifdef HS_MDU_EN
   localparam int MD_MAX = (MD_DIV_CYC > MD_MULT_CYC) ? MD_DIV_CYC : MD_MULT_CYC;
   localparam int MDW    = $clog2(MD_MAX + 1);

   logic [MDW-1:0] md_cnt;

   // Loads at issue, so an MD consumer directly behind a start sees busy.
   // Flush deliberately leaves the counter alone: the unit keeps running.
   always_ff @(posedge clk) begin
      if (!reset_n)
         md_cnt <= '0;
      else if (issue && d_md_start)
         md_cnt <= d_md_div ? MDW'(MD_DIV_CYC) : MDW'(MD_MULT_CYC);
      else if (md_cnt != '0)
         md_cnt <= md_cnt - MDW'(1);
   end

   assign md_busy  = (md_cnt != '0);
   assign md_stall = d_valid & d_md_use & md_busy;
`else
   localparam int unused_md_cyc = MD_MULT_CYC + MD_DIV_CYC;
   logic unused_md_in;
   assign unused_md_in = ^{d_md_start, d_md_div, d_md_use};
   assign md_busy      = 1'b0;
   assign md_stall     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : self-checking bench for hazard_scoreboard; directed hazard scenarios then random traffic.
// Latency : expectations are computed per cycle from a writer-history model and checked at the falling edge.
// Backpressure: the model applies the stall it predicted when deciding whether D issued at the next edge.
module tb_hazard_scoreboard;
   localparam int NREAD       = 2;
   localparam int NSTAGE      = 3;
   localparam int TW          = 2;
   localparam int MD_MULT_CYC = 5;
   localparam int MD_DIV_CYC  = 10;
   localparam int SELW        = $clog2(NSTAGE + 1);

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  d_valid, d_we, d_md_start, d_md_div, d_md_use, flush;
   logic [4:0]            d_a3;
   logic [TW-1:0]         d_tnew;
   logic [NREAD*5-1:0]    d_src;
   logic [NREAD*TW-1:0]   d_tuse;
   logic                  stall, md_busy;
   logic [NREAD*SELW-1:0] fwd_sel;

   hazard_scoreboard #(
      .NREAD(NREAD), .NSTAGE(NSTAGE), .TW(TW),
      .MD_MULT_CYC(MD_MULT_CYC), .MD_DIV_CYC(MD_DIV_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_we(d_we), .d_a3(d_a3),
      .d_tnew(d_tnew), .d_src(d_src), .d_tuse(d_tuse), .d_md_start(d_md_start),
      .d_md_div(d_md_div), .d_md_use(d_md_use), .flush(flush),
      .stall(stall), .fwd_sel(fwd_sel), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                    stall;
      logic [NREAD*SELW-1:0] fwd;
      bit                    busy;
   } exp_t;

   // hist[k] = writer that entered E k-1 edges ago, with its original tnew
   typedef struct {
      bit v;
      int a3;
      int tnew0;
   } wr_t;

   wr_t  hist [1:NSTAGE];
   exp_t exp_q [$];
   int   cyc = 0;
   int   busy_until = 0;
   bit   known = 0;
   bit   last_stall = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic exp_t model_out();
      exp_t e;
      bit   any;
      bit   busy;
      e.fwd = '0;
      any   = 0;
      for (int c = 0; c < NREAD; c++) begin
         int s;
         int u;
         s = int'(d_src[5*c +: 5]);
         u = int'(d_tuse[TW*c +: TW]);
         for (int k = 1; k <= NSTAGE; k++) begin
            if (hist[k].v && hist[k].a3 == s && s != 0) begin
               int t;
               t = hist[k].tnew0 - (k - 1);
               if (t < 0) t = 0;
               if (t > u) any = 1;
               if (t == 0) e.fwd[SELW*c +: SELW] = SELW'(k);
               break;
            end
         end
      end
`ifdef HS_MDU_EN
      busy = (cyc < busy_until);
      e.stall = d_valid && (any || (d_md_use && busy));
`else
      busy = 0;
      e.stall = d_valid && any;
`endif
      e.busy = busy;
      return e;
   endfunction

   task automatic model_edge();
      bit iss;
      cyc++;
      if (!reset_n) begin
         for (int k = 1; k <= NSTAGE; k++) hist[k] = '{0, 0, 0};
         busy_until = 0;
         known = 1;
      end else if (known) begin
         iss = d_valid && !last_stall;
`ifdef HS_MDU_EN
         if (iss && d_md_start)
            busy_until = cyc + (d_md_div ? MD_DIV_CYC : MD_MULT_CYC);
`endif
         if (flush) begin
            for (int k = 1; k <= NSTAGE; k++) hist[k] = '{0, 0, 0};
         end else begin
            for (int k = NSTAGE; k >= 2; k--) hist[k] = hist[k-1];
            hist[1] = '{iss && d_we && d_a3 != 0, int'(d_a3), int'(d_tnew)};
         end
      end
   endtask

   // One cycle: the previous inputs take effect at this edge, then new
   // inputs are applied and their expected response queued.
   task automatic step(input bit v, input bit we, input int a3, input int tn,
                       input int s0, input int u0, input int s1, input int u1,
                       input bit ms, input bit md, input bit mu, input bit fl, input bit rn);
      exp_t e;
      @(posedge clk);
      model_edge();
      #1;
      d_valid = v; d_we = we; d_a3 = 5'(a3); d_tnew = TW'(tn);
      d_src = {5'(s1), 5'(s0)};
      d_tuse = {TW'(u1), TW'(u0)};
      d_md_start = ms; d_md_div = md; d_md_use = mu; flush = fl; reset_n = rn;
      if (known) begin
         e = model_out();
         last_stall = e.stall;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall", int'(stall), int'(e.stall));
            check("md_busy", int'(md_busy), int'(e.busy));
            for (int c = 0; c < NREAD; c++)
               check($sformatf("fwd_sel[%0d]", c), int'(fwd_sel[SELW*c +: SELW]),
                     int'(e.fwd[SELW*c +: SELW]));
         end
      end
   end

   initial begin
      reset_n = 0; d_valid = 0; d_we = 0; d_a3 = 0; d_tnew = 0; d_src = 0; d_tuse = 0;
      d_md_start = 0; d_md_div = 0; d_md_use = 0; flush = 0;
      for (int k = 1; k <= NSTAGE; k++) hist[k] = '{0, 0, 0};

      // Reset held with random inputs, then released with D empty.
      for (int i = 0; i < 2; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3),
              $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      idle(2);

      // Load-use: lw $8 (tnew 2) then a reader of $8 with tuse 0, held in D.
      step(1, 1, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 9, 1, 8, 0, 3, 3, 0, 0, 0, 0, 1);
      idle(3);

      // ALU chain to the same destination; youngest writer must win.
      step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);

      // Register zero never matches.
      step(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);

      // div then mflo held in D.
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
      for (int i = 0; i < 12; i++) step(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      idle(3);

      // mult running, lw $8, stalled reader, then flush for one cycle.
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
      step(1, 1, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(8);

      // Random traffic over a small register set to provoke hazards.
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 9) == 0, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
      idle(2);

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
